// File: rtl/text_pkg.sv
// Shared constants, control codes and FSM state type for the text-buffer writer.
package text_pkg;

  localparam int unsigned TXT_COLS  = 80;
  localparam int unsigned TXT_ROWS  = 30;
  localparam int unsigned TXT_DEPTH = TXT_COLS * TXT_ROWS;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned COL_W     = 7;
  localparam int unsigned ROW_W     = 5;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ROW = 2'd1,
    CLEAR_ALL = 2'd2
  } state_t;

  // row*80 as (row<<6)+(row<<4); avoids a multiplier
  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
    return (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4);
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
module text_ram
  import text_pkg::*;
#(
  parameter int unsigned DEPTH = TXT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_q;
  logic       oor_q;

  // Array carries no reset so it maps onto block RAM; read-before-write
  always_ff @(posedge clk) begin
    if (we && (wr_addr < ADDR_W'(DEPTH))) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  // Out-of-range flag also forces rd_data to zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oor_q <= 1'b1;
    else        oor_q <= (rd_addr >= ADDR_W'(DEPTH));
  end

  assign rd_data = oor_q ? 8'h00 : rd_q;

endmodule

// File: rtl/text_buffer_writer.sv
// UART byte stream to 80x30 character RAM: cursor tracking, control codes, clears.
module text_buffer_writer
  import text_pkg::*;
#(
  parameter int unsigned COLS  = TXT_COLS,
  parameter int unsigned ROWS  = TXT_ROWS,
  parameter logic [7:0]  BLANK = CH_BLANK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              ovr_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned DEPTH = COLS * ROWS;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  cnt, cnt_n;
  logic [COL_W-1:0]   col_n;
  logic [ROW_W-1:0]   row_n, row_inc;
  logic               pend_vld, pend_vld_n;
  logic [7:0]         pend_byte, pend_byte_n;
  logic               overrun_n, busy_n;
  logic               proc, drop;
  logic [7:0]         byte_c;
  logic               we_c;
  logic [ADDR_W-1:0]  wa_c;
  logic [7:0]         wd_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR_ALL;
      cnt        <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      pend_vld   <= 1'b0;
      pend_byte  <= '0;
      overrun    <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cursor_col <= col_n;
      cursor_row <= row_n;
      pend_vld   <= pend_vld_n;
      pend_byte  <= pend_byte_n;
      overrun    <= overrun_n;
      busy       <= busy_n;
    end
  end

  assign row_inc = (cursor_row == ROW_W'(ROWS - 1)) ? '0 : cursor_row + 1'b1;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    col_n       = cursor_col;
    row_n       = cursor_row;
    pend_vld_n  = pend_vld;
    pend_byte_n = pend_byte;
    overrun_n   = overrun;
    proc        = 1'b0;
    drop        = 1'b0;
    byte_c      = pend_byte;
    we_c        = 1'b0;
    wa_c        = '0;
    wd_c        = BLANK;

    case (state)
      IDLE: begin
        // Pending byte has priority; a same-cycle arrival refills the slot
        if (pend_vld) begin
          proc       = 1'b1;
          byte_c     = pend_byte;
          pend_vld_n = rx_dv;
          if (rx_dv) pend_byte_n = rx_byte;
        end else if (rx_dv) begin
          proc   = 1'b1;
          byte_c = rx_byte;
        end
      end
      CLEAR_ROW: begin
        we_c = 1'b1;
        wa_c = row_base(cursor_row) + cnt;
        if (cnt == ADDR_W'(COLS - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CLEAR_ALL: begin
        we_c = 1'b1;
        wa_c = cnt;
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = CLEAR_ALL;
    endcase

    if ((state != IDLE) && rx_dv) begin
      if (!pend_vld) begin
        pend_vld_n  = 1'b1;
        pend_byte_n = rx_byte;
      end else begin
        drop = 1'b1;
      end
    end

    if (proc) begin
      if ((byte_c >= 8'h20) && (byte_c <= 8'h7E)) begin
        we_c = 1'b1;
        wa_c = row_base(cursor_row) + ADDR_W'(cursor_col);
        wd_c = byte_c;
        if (cursor_col == COL_W'(COLS - 1)) begin
          col_n   = '0;
          row_n   = row_inc;
          state_n = CLEAR_ROW;
          cnt_n   = '0;
        end else begin
          col_n = cursor_col + 1'b1;
        end
      end else begin
        case (byte_c)
          CH_CR: col_n = '0;
          CH_LF: begin
            row_n   = row_inc;
            state_n = CLEAR_ROW;
            cnt_n   = '0;
          end
          CH_BS: begin
            if (cursor_col != '0) begin
              col_n = cursor_col - 1'b1;
              we_c  = 1'b1;
              wa_c  = row_base(cursor_row) + ADDR_W'(cursor_col - 1'b1);
              wd_c  = BLANK;
            end
          end
          CH_FF: begin
            col_n   = '0;
            row_n   = '0;
            state_n = CLEAR_ALL;
            cnt_n   = '0;
          end
          default: ;
        endcase
      end
    end

    // A drop in the same cycle as a clear request leaves the flag set
    if (ovr_clr) overrun_n = 1'b0;
    if (drop)    overrun_n = 1'b1;

    busy_n = (state_n != IDLE);
  end

  text_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we_c),
    .wr_addr (wa_c),
    .wr_data (wd_c),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer: reads checked against a scoreboard queue.
module tb_text_buffer_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        ovr_clr;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  text_buffer_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .ovr_clr    (ovr_clr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  // Expected byte queued with the request, compared when rd_data is valid
  task automatic read_cell(input string tag, input logic [11:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    chk(tag, rd_data, exp_q.pop_front());
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_cursor(input string tag, input int c, input int r);
    chk({tag, "_col"}, cursor_col, c);
    chk({tag, "_row"}, cursor_row, r);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = '0; ovr_clr = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk_cursor("rst", 0, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    wait_idle(n);
    chk("clear_all_cycles", n, 2400);
    read_cell("blank_0", 12'd0, 8'h20);
    read_cell("blank_1234", 12'd1234, 8'h20);
    read_cell("blank_2399", 12'd2399, 8'h20);
    read_cell("oor_2400", 12'd2400, 8'h00);
    read_cell("oor_4095", 12'd4095, 8'h00);

    send(8'h41);
    send(8'h42);
    chk_cursor("ab", 2, 0);
    read_cell("cell0_A", 12'd0, 8'h41);
    read_cell("cell1_B", 12'd1, 8'h42);

    send(8'h01);
    chk_cursor("ignored", 2, 0);
    chk("ignored_busy", busy, 0);

    send(8'h0D);
    chk_cursor("cr", 0, 0);
    for (int i = 0; i < 80; i++) send(8'h78);
    chk("wrap_busy", busy, 1);
    chk_cursor("wrap", 0, 1);
    wait_idle(n);
    chk("clear_row_cycles", n, 80);
    read_cell("row0_x0", 12'd0, 8'h78);
    read_cell("row0_x79", 12'd79, 8'h78);
    for (int a = 80; a < 160; a++) read_cell("row1_blank", 12'(a), 8'h20);

    for (int i = 0; i < 28; i++) begin
      send(8'h0A);
      wait_idle(n);
    end
    chk_cursor("row29", 0, 29);
    send(8'h0A);
    chk_cursor("lf_wrap", 0, 0);
    wait_idle(n);
    chk("lf_clear_cycles", n, 80);
    read_cell("lf_blank0", 12'd0, 8'h20);
    read_cell("lf_blank79", 12'd79, 8'h20);

    send(8'h51);
    read_cell("cell0_Q", 12'd0, 8'h51);
    send(8'h08);
    chk_cursor("bs1", 0, 0);
    send(8'h08);
    chk_cursor("bs2", 0, 0);
    read_cell("bs_blank0", 12'd0, 8'h20);

    send(8'h61);
    send(8'h62);
    send(8'h08);
    chk_cursor("bs_mid", 1, 0);
    read_cell("bs_mid0", 12'd0, 8'h61);
    read_cell("bs_mid1", 12'd1, 8'h20);

    send(8'h0C);
    chk_cursor("ff", 0, 0);
    wait_idle(n);
    chk("ff_clear_cycles", n, 2400);
    read_cell("ff_blank0", 12'd0, 8'h20);

    send(8'h0C);
    send(8'h4D);
    chk("pend_no_ovr", overrun, 0);
    send(8'h4E);
    chk("drop_ovr", overrun, 1);
    send(8'h4F);
    wait_idle(n);
    @(posedge clk);
    #1;
    chk_cursor("pend_done", 1, 0);
    read_cell("pend_M", 12'd0, 8'h4D);
    read_cell("drop_N", 12'd1, 8'h20);
    chk("ovr_sticky", overrun, 1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);

    send(8'h0C);
    send(8'h50);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'h52; ovr_clr = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0; ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    wait_idle(n);
    @(posedge clk);
    #1;
    chk_cursor("pend_P", 1, 0);
    read_cell("cell0_P", 12'd0, 8'h50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_buffer_writer.md
# text_buffer_writer

Character-cell writer that sits directly upstream of the VGA text renderer. It consumes bytes from the UART receiver (`o_Rx_DV` / `o_Rx_Byte`) and keeps a cursor. It writes printable characters into an 80×30 dual-port text RAM and interprets a small set of control codes. The renderer reads the RAM through a registered read port, indexed from the current pixel counters.

## Interface
- `COLS`, default 80: characters per row.
- `ROWS`, default 30: rows per screen.
- `BLANK`, default 8'h20: fill code used by all clear operations.
- `clk`  in  1: pixel clock (25 MHz); single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rx_dv`  in  1: one-cycle strobe; `rx_byte` is valid.
- `rx_byte`  in  8: received byte.
- `ovr_clr`  in  1: clears `overrun`.
- `rd_addr`  in  12: renderer read address, `row*COLS+col`.
- `rd_data`  out  8: character code at `rd_addr`, registered.
- `cursor_col`  out  7: current column, 0..COLS-1.
- `cursor_row`  out  5: current row, 0..ROWS-1.
- `busy`  out  1: high when the FSM is not in IDLE.
- `overrun`  out  1: sticky flag; a byte was dropped.

## Operation
- FSM states: IDLE, CLEAR_ROW, CLEAR_ALL.
- On reset the FSM enters CLEAR_ALL, so `busy`=1 out of reset.
- One-deep pending register. A byte arriving while `busy`=1 is stored there.
- A byte arriving while the pending register is full is dropped and sets `overrun`.
- In IDLE, a pending byte is processed before a new `rx_dv`. A new `rx_dv` in that same cycle goes into the pending register.
- Byte decode in IDLE:
  - 0x20–0x7E: write the byte at the cursor, then advance the column.
  - Advancing from col COLS-1 moves to col 0 of row+1 (row ROWS-1 wraps to row 0), then enters CLEAR_ROW for the new row.
  - 0x0D (CR): col←0.
  - 0x0A (LF): row←row+1 with wrap; col unchanged; enter CLEAR_ROW.
  - 0x08 (BS): if col>0, col←col-1 and write BLANK at the new cursor. At col 0 it is a no-op.
  - 0x0C (FF): cursor←(0,0); enter CLEAR_ALL.
  - Any other byte: ignored; consumes no cycles beyond decode.
- CLEAR_ROW writes BLANK to the COLS cells of the cursor row, one per cycle, then returns to IDLE. The cursor is not moved.
- CLEAR_ALL writes BLANK to addresses 0..COLS*ROWS-1, one per cycle, then returns to IDLE.
- Address arithmetic: `row*80 = (row<<6)+(row<<4)`, computed in 12 bits, no multiplier.
- Read addresses ≥ COLS*ROWS return 8'h00.
- `ovr_clr` clears `overrun`. If `ovr_clr` coincides with a new drop, the set wins.
- Reset mid-clear: asynchronous abort. The clear restarts from address 0 in CLEAR_ALL; the pending byte is discarded. RAM contents are not reset.

## Timing
- Reset values:
  - `cursor_col`=0, `cursor_row`=0.
  - `busy`=1 (CLEAR_ALL).
  - `overrun`=0.
  - `rd_data`=0.
  - Pending register empty.
- Printable byte with `rx_dv` at cycle N in IDLE: RAM write and cursor update both land at the N+1 edge. The next byte is accepted at N+1.
- CLEAR_ROW: `busy` high for exactly COLS (80) cycles after the decode cycle.
- CLEAR_ALL: `busy` high for exactly COLS*ROWS (2400) cycles. This exceeds one byte time at 115200 baud (~2170 cycles), which is why the pending register exists.
- Read port: `rd_data` valid one cycle after `rd_addr`.
- A same-cycle read and write to the same address returns the old data.
- `overrun` asserts the cycle after the dropped `rx_dv`.

## Structure
- Shared package `text_pkg`:
  - Constants `TXT_COLS`, `TXT_ROWS`, `TXT_DEPTH`=2400.
  - Control-code constants `CH_BS`, `CH_LF`, `CH_FF`, `CH_CR`, `CH_BLANK`.
  - FSM state typedef.
- Sub-module `text_ram`: simple dual-port RAM, 2400×8, one write port, one registered read port, with no reset on the array. Inferred as block RAM.
- The renderer instantiates `text_buffer_writer` and drives `rd_addr` from `CounterX>>3` and `CounterY>>4`.

## Test plan
- Reset, then wait 2400 cycles: `busy` falls at cycle 2400. Reading addresses 0, 1234, and 2399 returns 8'h20.
- Send 'A' (0x41), then 'B' (0x42): `rd_addr` 0 returns 0x41, `rd_addr` 1 returns 0x42, cursor=(2,0).
- Send 80 × 'x': the cursor wraps to (0,1). `busy` stays high for 80 cycles. Cells 80..159 read 0x20.
- With the cursor at (0,29), send LF: the cursor goes to (0,0) and row 0 is blanked over 80 cycles.
- Send 'Q', BS, BS: cell 0 reads 0x20 and the cursor is (0,0); the second BS is a no-op.
- Send FF, then three bytes within 2400 cycles: the first is buffered and written after the clear completes; the second and third are dropped. `overrun`=1 until `ovr_clr` is pulsed.
